ram8x72_bist: RTL
=================

# ram8x72_bist

Built-in self-test engine that drives the host side of the 8x72 flip-flop RAM (`wr_n`, `address`, `wdata`, `rdata`) in place of normal traffic. It runs a March C- sequence over all 8 words with all-zeros/all-ones backgrounds and compares every read. It reports pass/fail, the first failing address, element and bit syndrome, and an error count. It sits between the test/control register block and the RAM's write/address mux.

## Interface
- `RD_LAT`, default 1: cycles from read address presented to valid `ram_rdata`. Legal values: 0 or 1.
- `STOP_ON_FAIL`, default 1: 1 = abort on the first mismatch; 0 = run to completion and count all mismatches.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: begin a test run; level-sampled.
- `busy` out 1: test in progress.
- `done` out 1: test finished; held until the next accepted `start`.
- `pass` out 1: valid while `done`=1; no mismatches.
- `fail` out 1: valid while `done`=1; at least one mismatch.
- `fail_addr` out 3: address of the first mismatch.
- `fail_elem` out 3: March element (0–5) of the first mismatch.
- `fail_syndrome` out 72: expected XOR actual at the first mismatch.
- `err_count` out 6: total mismatches, saturating at 63.
- `ram_wr_n` out 1: active-low write strobe to the RAM.
- `ram_address` out 3: RAM address.
- `ram_wdata` out 72: RAM write data.
- `ram_rdata` in 72: RAM read data.

## Operation
- States: IDLE, OP, RWAIT, DONE.
- Reset puts the block in IDLE. Reset value of all outputs: `ram_wr_n`=1, `ram_address`=0, `ram_wdata`=0, `busy`=0, `done`=0, `pass`=0, `fail`=0, `fail_addr`=0, `fail_elem`=0, `fail_syndrome`=0, `err_count`=0.
- Start acceptance:
  - `start`=1 in IDLE or DONE is accepted.
  - On acceptance, clear `done`, `pass`, `fail`, all `fail_*` and `err_count`, set `busy`=1, and go to OP with element 0 at address 0.
  - `start` while `busy`=1 is ignored.
- March elements (D0 = 72'h0, D1 = all ones):
  - Element 0, ascending: w D0.
  - Element 1, ascending: r D0, w D1.
  - Element 2, ascending: r D1, w D0.
  - Element 3, descending: r D0, w D1.
  - Element 4, descending: r D1, w D0.
  - Element 5, ascending: r D0.
- Addressing:
  - Ascending elements run addresses 0→7; descending elements run 7→0.
  - All ops of an element complete at one address before the address advances.
- Write op: one cycle with `ram_wr_n`=0 and `ram_address`/`ram_wdata` valid. The RAM captures on the closing edge.
- Read op:
  - Issue cycle: `ram_wr_n`=1, `ram_address` valid.
  - With `RD_LAT`=1 the FSM spends one cycle in RWAIT holding the address.
  - Compare `ram_rdata` against expected on the closing edge of cycle issue+`RD_LAT`.
- Mismatch handling:
  - Every mismatch increments `err_count`.
  - The first mismatch captures `fail_addr`, `fail_elem` and `fail_syndrome`; later mismatches never overwrite them.
  - With `STOP_ON_FAIL`=1, the next state is DONE.
- DONE:
  - `busy`=0, `done`=1, `ram_wr_n`=1.
  - `fail` = (`err_count` != 0), `pass` = !`fail`.
  - `ram_wdata` is don't-care outside write cycles.
- Reset mid-run: all outputs return asynchronously to their reset values, `ram_wr_n` goes to 1 immediately, and no partial write is issued.

## Timing
- `start` is sampled at edge E0. `busy`=1 and the first write are driven during the cycle following E0.
- Op costs: writes take 1 cycle each (40 total); reads take 1+`RD_LAT` cycles each (40 total).
- Fault-free run length: 80 cycles for `RD_LAT`=0, 120 cycles for `RD_LAT`=1.
- Completion: on the edge after the last compare, `busy` falls and `done`/`pass`/`fail` rise together. No cycle has both `busy`=1 and `done`=1.
- Abort: with `STOP_ON_FAIL`=1, `done` rises on the edge after the failing compare.
- Back-to-back operation: a `start` held high in DONE restarts at the next edge, with `done` falling as `busy` rises.
- No combinational path from `ram_rdata` to any output; all outputs are registered.

## Test plan
- Fault-free RAM model, `RD_LAT`=1, 1-cycle `start` pulse → `busy` for exactly 120 cycles, then `done`=1, `pass`=1, `fail`=0, `err_count`=0. The write-strobe count equals 40.
- Stuck-at-1 on bit 5 of word 3, `STOP_ON_FAIL`=1 → `fail`=1, `fail_addr`=3, `fail_elem`=1, `fail_syndrome`=72'h20, `err_count`=1. `done` rises on the edge after that compare.
- Same fault, `STOP_ON_FAIL`=0 → full 120-cycle run, `err_count`=3 (r D0 in elements 1, 3, 5). Captured fields stay addr 3, elem 1.
- Stuck-at-0 on bit 71 of word 0, `RD_LAT`=0 → `fail_elem`=2, `fail_addr`=0, `fail_syndrome`=72'h80_0000_0000_0000_0000. Fault-free run takes 80 cycles.
- `rst` asserted mid-element-3 → within the same cycle `ram_wr_n`=1 and `busy`=0. A new `start` after release runs a full pass.
- `start` re-pulsed while `busy` → ignored, the run length is unchanged. `start` held high after `done` → immediate restart with `err_count` cleared.

Source files
------------

// File: rtl/ram8x72_bist.sv
// March C- self-test engine for the 8x72 flip-flop RAM: drives the RAM host port,
// compares every read and records the first failure plus a saturating error count.
module ram8x72_bist #(
  parameter int RD_LAT       = 1,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [2:0]  fail_addr,
  output logic [2:0]  fail_elem,
  output logic [71:0] fail_syndrome,
  output logic [5:0]  err_count,
  output logic        ram_wr_n,
  output logic [2:0]  ram_address,
  output logic [71:0] ram_wdata,
  input  logic [71:0] ram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OP    = 2'd1,
    ST_RWAIT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [71:0] PAT_D0  = {72{1'b0}};
  localparam logic [71:0] PAT_D1  = {72{1'b1}};
  localparam logic [5:0]  ERR_MAX = 6'd63;

  state_t       state_q, state_d;
  logic [2:0]   elem_q, elem_d;
  logic         opi_q, opi_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         pass_q, pass_d;
  logic         fail_q, fail_d;
  logic [2:0]   fail_addr_q, fail_addr_d;
  logic [2:0]   fail_elem_q, fail_elem_d;
  logic [71:0]  fail_syndrome_q, fail_syndrome_d;
  logic [5:0]   err_count_q, err_count_d;
  logic         ram_wr_n_q, ram_wr_n_d;
  logic [2:0]   ram_address_q, ram_address_d;
  logic [71:0]  ram_wdata_q, ram_wdata_d;

  logic [2:0]   nxt_elem_s;
  logic [2:0]   nxt_addr_s;
  logic         nxt_opi_s;
  logic         last_op_s;
  logic         compare_s;
  logic         advance_s;
  logic         mismatch_s;
  logic [71:0]  syndrome_s;

  function automatic logic is_desc(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // Element 0 is a lone write; elements 1-4 are read-then-write; element 5 is a lone read.
  function automatic logic op_is_write(input logic [2:0] e, input logic o);
    return (e == 3'd0) || o;
  endfunction

  function automatic logic [71:0] wr_pattern(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? PAT_D1 : PAT_D0;
  endfunction

  function automatic logic [71:0] rd_expect(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? PAT_D1 : PAT_D0;
  endfunction

  // Sequencer position following the current op; last_op_s marks the final read of element 5.
  always_comb begin
    nxt_elem_s = elem_q;
    nxt_addr_s = ram_address_q;
    nxt_opi_s  = 1'b0;
    last_op_s  = 1'b0;
    if (!opi_q && (elem_q != 3'd0) && (elem_q != 3'd5)) begin
      nxt_opi_s = 1'b1;
    end else if (ram_address_q != (is_desc(elem_q) ? 3'd0 : 3'd7)) begin
      nxt_addr_s = is_desc(elem_q) ? (ram_address_q - 3'd1) : (ram_address_q + 3'd1);
    end else if (elem_q == 3'd5) begin
      last_op_s = 1'b1;
    end else begin
      nxt_elem_s = elem_q + 3'd1;
      nxt_addr_s = is_desc(elem_q + 3'd1) ? 3'd7 : 3'd0;
    end
  end

  // FSM next state, compare/capture logic and next values of every registered output.
  always_comb begin
    state_d         = state_q;
    elem_d          = elem_q;
    opi_d           = opi_q;
    busy_d          = busy_q;
    done_d          = done_q;
    pass_d          = pass_q;
    fail_d          = fail_q;
    fail_addr_d     = fail_addr_q;
    fail_elem_d     = fail_elem_q;
    fail_syndrome_d = fail_syndrome_q;
    err_count_d     = err_count_q;
    ram_wr_n_d      = ram_wr_n_q;
    ram_address_d   = ram_address_q;
    ram_wdata_d     = ram_wdata_q;
    compare_s       = 1'b0;
    advance_s       = 1'b0;
    syndrome_s      = rd_expect(elem_q) ^ ram_rdata;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d         = ST_OP;
          elem_d          = 3'd0;
          opi_d           = 1'b0;
          busy_d          = 1'b1;
          done_d          = 1'b0;
          pass_d          = 1'b0;
          fail_d          = 1'b0;
          fail_addr_d     = 3'd0;
          fail_elem_d     = 3'd0;
          fail_syndrome_d = PAT_D0;
          err_count_d     = 6'd0;
          ram_wr_n_d      = 1'b0;
          ram_address_d   = 3'd0;
          ram_wdata_d     = PAT_D0;
        end else begin
          state_d = state_q;
        end
      end
      ST_OP: begin
        if (op_is_write(elem_q, opi_q)) begin
          advance_s = 1'b1;
        end else if (RD_LAT == 0) begin
          compare_s = 1'b1;
          advance_s = 1'b1;
        end else begin
          state_d = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        compare_s = 1'b1;
        advance_s = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mismatch_s = compare_s && (syndrome_s != PAT_D0);

    // Only the first mismatch of a run is captured; the count keeps going up to saturation.
    if (mismatch_s) begin
      if (err_count_q != ERR_MAX) begin
        err_count_d = err_count_q + 6'd1;
      end else begin
        err_count_d = err_count_q;
      end
      if (err_count_q == 6'd0) begin
        fail_addr_d     = ram_address_q;
        fail_elem_d     = elem_q;
        fail_syndrome_d = syndrome_s;
      end else begin
        fail_addr_d = fail_addr_q;
      end
    end else begin
      err_count_d = err_count_d;
    end

    if (advance_s) begin
      if (last_op_s || (mismatch_s && (STOP_ON_FAIL != 0))) begin
        state_d    = ST_DONE;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        ram_wr_n_d = 1'b1;
        fail_d     = (err_count_d != 6'd0);
        pass_d     = (err_count_d == 6'd0);
      end else begin
        state_d       = ST_OP;
        elem_d        = nxt_elem_s;
        opi_d         = nxt_opi_s;
        ram_address_d = nxt_addr_s;
        ram_wr_n_d    = !op_is_write(nxt_elem_s, nxt_opi_s);
        ram_wdata_d   = wr_pattern(nxt_elem_s);
      end
    end else begin
      opi_d = opi_d;
    end
  end

  // State and output registers; reset forces the write strobe inactive at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      elem_q          <= 3'd0;
      opi_q           <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      fail_q          <= 1'b0;
      fail_addr_q     <= 3'd0;
      fail_elem_q     <= 3'd0;
      fail_syndrome_q <= {72{1'b0}};
      err_count_q     <= 6'd0;
      ram_wr_n_q      <= 1'b1;
      ram_address_q   <= 3'd0;
      ram_wdata_q     <= {72{1'b0}};
    end else begin
      state_q         <= state_d;
      elem_q          <= elem_d;
      opi_q           <= opi_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      fail_q          <= fail_d;
      fail_addr_q     <= fail_addr_d;
      fail_elem_q     <= fail_elem_d;
      fail_syndrome_q <= fail_syndrome_d;
      err_count_q     <= err_count_d;
      ram_wr_n_q      <= ram_wr_n_d;
      ram_address_q   <= ram_address_d;
      ram_wdata_q     <= ram_wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign fail_addr     = fail_addr_q;
  assign fail_elem     = fail_elem_q;
  assign fail_syndrome = fail_syndrome_q;
  assign err_count     = err_count_q;
  assign ram_wr_n      = ram_wr_n_q;
  assign ram_address   = ram_address_q;
  assign ram_wdata     = ram_wdata_q;

endmodule
